// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 encryptor, one round per clock, on-chip key expansion.
// Ports: clk; rst_n (sync, active-low);
//   key_size/key_in/key_valid/key_ready : key load (key left-aligned in key_in)
//   din/din_valid/din_ready             : plaintext block in
//   dout/dout_valid/dout_ready          : ciphertext block out, held until taken
//   key_err : one-cycle pulse on a rejected key;  busy : key expansion or rounds in progress
module aes_iter_core #(
   parameter int MAX_KEY          = 256,
   parameter bit RESET_CLEAR_KEYS = 1'b1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   key_size,
   input  logic [255:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic [127:0] dout,
   output logic         dout_valid,
   input  logic         dout_ready,
   output logic         key_err,
   output logic         busy
);
   localparam int DEPTH = 4 * (MAX_KEY / 32 + 7);
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, KEXP, READY, ROUND, HOLD} state_t;
   state_t state, state_nx;

   // word k of the key schedule lives at bits [32k +: 32]
   logic [DEPTH*32-1:0] w;
   logic [255:0]        kw;
   logic [AW-1:0]       i, last;
   logic [3:0]          nk, nr, r, rsel;
   logic [2:0]          j;
   logic [7:0]          rcon;
   logic [127:0]        st, rk, round_out;
   logic [31:0]         w_prev, w_back, sub_in, sub_out, temp, w_new;
   logic [7:0]          sb [16];
   logic [7:0]          sr [16];
   logic [7:0]          mc [16];
   logic                init, key_fire, key_bad, din_fire;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int k = 0; k < 8; k++) begin
         p = b[k] ? p ^ x : p;
         x = xt(x);
      end
      return p;
   endfunction

   // forward S-box: multiplicative inverse (a^254) followed by the FIPS-197 affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] y;
      y = a;
      for (int k = 0; k < 6; k++) y = gm(gm(y, y), a);
      y = gm(y, y);
      return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
   endfunction

   assign key_bad  = key_size == 2'b11 || (key_size == 2'b10 && MAX_KEY < 256) ||
                     (key_size == 2'b01 && MAX_KEY < 192);
   assign key_fire = key_valid && key_ready;
   // a key offered together with a block wins; the block stays pending
   assign din_fire = din_valid && din_ready && !key_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (key_fire)                           state_nx = key_bad ? IDLE : KEXP;
      else if (din_fire)                      state_nx = ROUND;
      else if (state == KEXP && i == last)    state_nx = READY;
      else if (state == ROUND && r == nr)     state_nx = HOLD;
      else if (state == HOLD && dout_ready)   state_nx = READY;
   end

   // init holds key_ready low for the cycle right after reset
   always_comb begin
      key_ready  = (state == IDLE || state == READY) && !init;
      din_ready  = state == READY;
      dout_valid = state == HOLD;
      busy       = state == KEXP || state == ROUND;
   end

   always_comb begin
      kw = '0;
      for (int k = 0; k < 8; k++) kw[32*k +: 32] = key_in[255-32*k -: 32];
   end

   // key expansion: j tracks i mod Nk
   always_comb begin
      w_prev  = w[{i - AW'(1), 5'b0} +: 32];
      w_back  = w[{i - AW'(nk), 5'b0} +: 32];
      sub_in  = (j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
      sub_out = '0;
      for (int k = 0; k < 4; k++) sub_out[8*k +: 8] = sbox(sub_in[8*k +: 8]);
      temp    = (j == 3'd0) ? sub_out ^ {rcon, 24'h0} :
                (nk == 4'd8 && j == 3'd4) ? sub_out : w_prev;
      w_new   = w_back ^ temp;
   end

   assign rsel = (state == ROUND) ? r : 4'd0;
   assign rk   = {w[{rsel, 2'd0, 5'b0} +: 32], w[{rsel, 2'd1, 5'b0} +: 32],
                  w[{rsel, 2'd2, 5'b0} +: 32], w[{rsel, 2'd3, 5'b0} +: 32]};

   always_comb begin
      sb = '{default: '0};
      sr = '{default: '0};
      mc = '{default: '0};
      round_out = '0;
      for (int k = 0; k < 16; k++) sb[k] = sbox(st[127-8*k -: 8]);
      for (int c = 0; c < 4; c++)
         for (int q = 0; q < 4; q++) sr[4*c+q] = sb[4*((c+q)%4)+q];
      for (int c = 0; c < 4; c++) begin
         mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
      end
      for (int k = 0; k < 16; k++)
         round_out[127-8*k -: 8] = ((r == nr) ? sr[k] : mc[k]) ^ rk[127-8*k -: 8];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         init    <= 1'b1;
         key_err <= 1'b0;
         dout    <= '0;
         st      <= '0;
         r       <= '0;
         rcon    <= 8'h01;
         i       <= '0;
         j       <= '0;
         last    <= '0;
         nk      <= 4'd4;
         nr      <= 4'd10;
      end else begin
         init    <= 1'b0;
         key_err <= key_fire && key_bad;
         if (key_fire && !key_bad) begin
            nk   <= key_size == 2'b00 ? 4'd4 : key_size == 2'b01 ? 4'd6 : 4'd8;
            nr   <= key_size == 2'b00 ? 4'd10 : key_size == 2'b01 ? 4'd12 : 4'd14;
            i    <= key_size == 2'b00 ? AW'(4) : key_size == 2'b01 ? AW'(6) : AW'(8);
            last <= key_size == 2'b00 ? AW'(43) : key_size == 2'b01 ? AW'(51) : AW'(59);
            j    <= '0;
            rcon <= 8'h01;
         end
         if (state == KEXP) begin
            i    <= i + AW'(1);
            j    <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
            rcon <= (j == 3'd0) ? xt(rcon) : rcon;
         end
         if (din_fire) begin
            st <= din ^ rk;
            r  <= 4'd1;
         end
         if (state == ROUND) begin
            st   <= round_out;
            r    <= r + 4'd1;
            dout <= (r == nr) ? round_out : dout;
         end
      end
   end

   // words beyond Nk in the initial load are overwritten by expansion before use
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if (RESET_CLEAR_KEYS) w <= '0;
      end else if (key_fire && !key_bad) w[255:0] <= kw;
      else if (state == KEXP) w[{i, 5'b0} +: 32] <= w_new;
   end
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: directed FIPS-197 vectors, handshake timing, key rejection, backpressure and reset abort.
module tb_aes_iter_core;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   key_size = '0;
   logic [255:0] key_in = '0;
   logic         key_valid = 1'b0, key_valid2 = 1'b0;
   logic [127:0] din = '0;
   logic         din_valid = 1'b0, dout_ready = 1'b0;
   logic         key_ready, din_ready, dout_valid, key_err, busy;
   logic [127:0] dout;
   logic         key_ready2, din_ready2, dout_valid2, key_err2, busy2;
   logic [127:0] dout2;
   int           n_cmp = 0, n_bad = 0;

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'hffeeddccbbaa99887766554433221100};
   localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hdeadbeefcafef00d};
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;

   aes_iter_core dut (
      .clk(clk), .rst_n(rst_n), .key_size(key_size), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .key_err(key_err), .busy(busy)
   );

   aes_iter_core #(.MAX_KEY(128)) dut2 (
      .clk(clk), .rst_n(rst_n), .key_size(key_size), .key_in(key_in), .key_valid(key_valid2),
      .key_ready(key_ready2), .din(din), .din_valid(1'b0), .din_ready(din_ready2),
      .dout(dout2), .dout_valid(dout_valid2), .dout_ready(1'b0), .key_err(key_err2), .busy(busy2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [1:0] sz, input logic [255:0] k);
      int n = 0;
      while (!key_ready && n < 100) begin
         n++;
         tick();
      end
      check("key_ready wait", key_ready, 1);
      key_size = sz;
      key_in = k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic kexp_count(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic encrypt(input logic [127:0] pt, output logic [127:0] ct, output int lat);
      int n = 0;
      while (!din_ready && n < 100) begin
         n++;
         tick();
      end
      check("din_ready wait", din_ready, 1);
      din = pt;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      lat = 0;
      while (!dout_valid && lat < 40) begin
         lat++;
         tick();
      end
      ct = dout;
   endtask

   task automatic drain;
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      check("hold exit dout_valid", dout_valid, 0);
      check("hold exit din_ready", din_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] ct;
      int n, lat;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst key_ready", key_ready, 0);
      check("rst din_ready", din_ready, 0);
      check("rst dout_valid", dout_valid, 0);
      check("rst dout", dout, 0);
      check("rst key_err", key_err, 0);
      check("rst busy", busy, 0);
      tick();
      check("post-rst key_ready", key_ready, 1);

      key_size = 2'b01;
      key_in = K192;
      key_valid2 = 1'b1;
      tick();
      key_valid2 = 1'b0;
      check("max128 key_err", key_err2, 1);
      check("max128 busy", busy2, 0);
      tick();
      check("max128 key_err end", key_err2, 0);
      check("max128 key_ready", key_ready2, 1);
      check("max128 din_ready", din_ready2, 0);

      send_key(2'b11, K256);
      check("bad key_err", key_err, 1);
      check("bad busy", busy, 0);
      tick();
      check("bad key_err end", key_err, 0);
      check("bad key_ready", key_ready, 1);
      din = PT;
      din_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bad din_ready", din_ready, 0);
      end
      din_valid = 1'b0;

      send_key(2'b00, K128);
      kexp_count(n);
      check("kexp128 cycles", 128'(n), 40);
      encrypt(PT, ct, lat);
      check("aes128 dout", ct, C128);
      check("aes128 latency", 128'(lat), 10);
      drain();

      key_size = 2'b10;
      key_in = K256;
      key_valid = 1'b1;
      din = PT;
      din_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      din_valid = 1'b0;
      check("switch busy", busy, 1);
      check("switch din_ready", din_ready, 0);
      kexp_count(n);
      check("kexp256 cycles", 128'(n), 52);
      encrypt(PT, ct, lat);
      check("aes256 dout", ct, C256);
      check("aes256 latency", 128'(lat), 14);
      drain();

      send_key(2'b01, K192);
      kexp_count(n);
      check("kexp192 cycles", 128'(n), 46);
      encrypt(PT, ct, lat);
      check("aes192 dout", ct, C192);
      check("aes192 latency", 128'(lat), 12);
      drain();

      send_key(2'b00, KB);
      kexp_count(n);
      check("kexpB cycles", 128'(n), 40);
      encrypt(PTB, ct, lat);
      check("bp latency", 128'(lat), 10);
      key_size = 2'b11;
      key_valid = 1'b1;
      din_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("bp dout", dout, CB);
         check("bp dout_valid", dout_valid, 1);
         check("bp din_ready", din_ready, 0);
         check("bp key_err", key_err, 0);
      end
      key_valid = 1'b0;
      din_valid = 1'b0;
      drain();

      send_key(2'b10, K256);
      kexp_count(n);
      check("kexp256b cycles", 128'(n), 52);
      din = PT;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort dout_valid", dout_valid, 0);
      check("abort busy", busy, 0);
      check("abort key_ready", key_ready, 0);
      check("abort dout", dout, 0);
      din_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("abort dout_valid run", dout_valid, 0);
         check("abort din_ready run", din_ready, 0);
      end
      din_valid = 1'b0;
      check("abort idle key_ready", key_ready, 1);
      send_key(2'b00, K128);
      check("reload din_ready", din_ready, 0);
      kexp_count(n);
      check("reload kexp cycles", 128'(n), 40);
      encrypt(PT, ct, lat);
      check("reload aes128 dout", ct, C128);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
